comefa_seq: RTL and testbench
=============================

# comefa_seq

Macro-op sequencer for one comefa compute RAM. It accepts ADD, COPY and FILL commands over a valid/ready handshake and expands each into a cycle-by-cycle stream of 40-bit compute commands on the RAM write port (`addr1 = CMD_ADDR`, `we1 = 1`). While idle it passes host storage-mode writes through to the same port. It sits between the host/CFU control logic and the comefa instance; the RAM read port is not routed through this block.

## Interface
- `AWIDTH`, 9, RAM word-address width
- `DWIDTH`, 40, RAM data and command width
- `CMD_ADDR`, 9'h1FF, address that selects compute mode
- `NUM_ROWS`, 128, internal rows; row index is 7 bits
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `cmd_valid` in 1: macro-op request
- `cmd_ready` out 1: sequencer idle and able to accept a macro-op
- `cmd_op` in 2: 00 ADD, 01 COPY, 10 FILL, 11 reserved
- `cmd_src1`, `cmd_src2`, `cmd_dst` in 7 each: operand base rows (MSB row)
- `cmd_width` in 5: operand width minus 1, giving W = 1..32
- `cmd_fill` in 1: constant bit used by FILL
- `cmd_cout` in 1: ADD writes the final carry to row `cmd_dst-1`
- `done` out 1: one-cycle pulse when a macro-op completes
- `err` out 1: one-cycle pulse, concurrent with `done`, when a macro-op is rejected
- `host_addr` in AWIDTH, `host_d` in DWIDTH, `host_we` in 1: host storage-mode write
- `host_ready` out 1: host write is accepted this cycle
- `cr_addr` out AWIDTH, `cr_d` out DWIDTH, `cr_we` out 1: registered drive of the comefa write port

## Operation
- **Operand layout.** W bits are stored one per row, MSB at the base row. Bit i (LSB = 0) lives at row `base + W - 1 - i`. Processing is LSB first.
- **States:**
  - IDLE → PRE on `cmd_valid & cmd_ready` when the command is legal.
  - PRE → BIT.
  - BIT: loops W times, then goes to COUT if ADD with `cmd_cout`, otherwise to IDLE.
  - COUT → IDLE.
- **Command fields.** Every issued command word uses predicate 11 and dummy 000.
- **PRE:** `c_rst = 1`, `write_en = 0`. Every op passes through PRE because sum = tt ^ cin, so cin must be 0 before the first bit.
- **BIT, ADD:** tt = 0110, `c_en = 1`, `write_sel = 01`, `port = 0`, `write_en = 1`. Source rows are src1/src2 at bit i; destination is dst at bit i.
- **BIT, COPY:** tt = 1010, `c_en = 0`, src2 field = 0.
- **BIT, FILL:** `b_sel = 1`, `b_data = cmd_fill`, tt = 1100; src1 and src2 fields = 0.
- **COUT:** `write_sel = 01`, `port = 1`, `write_en = 1`, destination row `dst - 1`. This writes the latched carry.
- **Rejection.** A command is rejected if `cmd_op = 11`, if any used base + W - 1 > 127, or if `cmd_cout` is set and `cmd_dst = 0`. A rejected command is still accepted by the handshake, issues no `cr_we`, and pulses `done` and `err` in the next cycle. Row overlap between operands is not checked.
- **Command capture.** All command fields are captured at acceptance; later input changes have no effect.
- **Host path.** `host_ready = 1` only in IDLE with no handshake this cycle. The macro-op handshake has priority over a simultaneous host write. An accepted host write is forwarded unchanged, including raw writes to `CMD_ADDR`.

## Timing
- **Reset:** state IDLE; `cr_we`, `done`, `err` = 0; `cr_addr`, `cr_d` = 0; `cmd_ready = 1`; `host_ready = 1`.
- **Handshake at cycle T:**
  - PRE word on `cr_*` at T+1.
  - Bit words at T+2 through T+1+W.
  - COUT word (if enabled) at T+2+W.
  - `done` in the cycle after the last word.
  - `cmd_ready` returns high in the same cycle as `done`, so back-to-back commands lose no cycle.
- **Host write:** accepted at T, appears on `cr_*` at T+1.
- **Idle output:** when no command word or host write is issued, `cr_we = 0`.
- **Reset mid-operation:** returns to IDLE on the next edge. No `done` pulse is produced and no further `cr_we` is issued. RAM contents already written are not reverted.

## Structure
- **Package `comefa_pkg`:**
  - command field bit positions: predicate 39:38, b_sel 34, b_data 33, write_en 32, write_sel 31:30, port 29, c_rst 28, c_en 27, m_rst 26, m_en 25, tt 24:21, dst 20:14, src2 13:7, src1 6:0
  - truth-table constants XOR, PASS1, PASS2
  - op codes and state enum
- **Sub-module `comefa_cmd_enc`:** combinational packer from named fields to the 40-bit word. The sequencer registers its output.

## Test plan
- **ADD, no carry write:** W=8, src1=3, src2=11, dst=19, per-column values 0x5A and 0x3C → dst column reads 0x96. Exactly 9 `cr_we` cycles; `done` at T+10.
- **ADD with carry write:** 0xF0 + 0x20 with `cmd_cout = 1`, dst=20 → dst column 0x10, row 19 = all ones. `done` at T+11.
- **FILL:** FILL with `cmd_fill = 1`, W=4, dst=40 → rows 40–43 all ones. COPY of those rows to dst=50 → rows 50–53 all ones.
- **Rejection:** src1=120, W=16 → no `cr_we`; `done` and `err` both at T+1. Repeat with `cmd_op = 11` → same response.
- **Host arbitration:** host write issued during ADD → `host_ready = 0` until `done`, then forwarded one cycle later. Host write in the same cycle as `cmd_valid` → command wins.
- **Reset and back-to-back:**
  - `reset` asserted at the 4th BIT cycle → `cr_we = 0` next cycle, no `done`, `cmd_ready = 1`.
  - `cmd_valid` held across two ADDs → second PRE word directly follows the first `done`.

Source files
------------

// File: rtl/comefa_pkg.sv
// Shared types and constants for the comefa macro-op sequencer.
// Field positions of the 40-bit compute word, truth tables, op codes, FSM states.
// Pure definitions; no timing or flow-control behaviour of its own.
package comefa_pkg;

    localparam int ROW_W = 7;
    localparam int CMD_W = 40;

    // Bit positions inside the compute command word (LSB of each field)
    localparam int POS_PRED  = 38;
    localparam int POS_BSEL  = 34;
    localparam int POS_BDATA = 33;
    localparam int POS_WEN   = 32;
    localparam int POS_WSEL  = 30;
    localparam int POS_PORT  = 29;
    localparam int POS_CRST  = 28;
    localparam int POS_CEN   = 27;
    localparam int POS_MRST  = 26;
    localparam int POS_MEN   = 25;
    localparam int POS_TT    = 21;
    localparam int POS_DST   = 14;
    localparam int POS_SRC2  = 7;
    localparam int POS_SRC1  = 0;

    // Truth tables indexed by {b, a}; a = src1 bit, b = src2 bit or b_data
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_PASS1 = 4'b1010;
    localparam logic [3:0] TT_PASS2 = 4'b1100;

    localparam logic [1:0] PRED_ALL = 2'b11;
    localparam logic [1:0] WSEL_SUM = 2'b01;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_COPY = 2'b01,
        OP_FILL = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_BIT,
        ST_COUT
    } state_e;

    // Which compute word (if any) is launched onto the RAM port next cycle
    typedef enum logic [1:0] {
        K_NONE,
        K_PRE,
        K_BIT,
        K_COUT
    } word_kind_e;

    typedef struct packed {
        logic [1:0]       pred;
        logic             b_sel;
        logic             b_data;
        logic             write_en;
        logic [1:0]       write_sel;
        logic             port;
        logic             c_rst;
        logic             c_en;
        logic             m_rst;
        logic             m_en;
        logic [3:0]       tt;
        logic [ROW_W-1:0] dst;
        logic [ROW_W-1:0] src2;
        logic [ROW_W-1:0] src1;
    } cmd_fields_t;

    // Highest row touched by an operand of width wm+1 based at 'base' (8 bits so overflow is visible)
    function automatic logic [7:0] top_row(input logic [ROW_W-1:0] base, input logic [4:0] wm);
        return {1'b0, base} + {3'b000, wm};
    endfunction

    // Row holding bit idx of an operand whose MSB sits at base
    function automatic logic [ROW_W-1:0] bit_row(input logic [ROW_W-1:0] base,
                                                 input logic [4:0] wm,
                                                 input logic [4:0] idx);
        return base + {2'b00, wm} - {2'b00, idx};
    endfunction

endpackage

// File: rtl/comefa_seq_if.sv
// Bundle of macro-op handshake, host write path and comefa write-port drive.
// No logic; latency is set by the modules on either side.
// cmd_valid/cmd_ready and host_we/host_ready carry the flow control.
interface comefa_seq_if #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 40
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [6:0]        cmd_src1;
    logic [6:0]        cmd_src2;
    logic [6:0]        cmd_dst;
    logic [4:0]        cmd_width;
    logic              cmd_fill;
    logic              cmd_cout;
    logic              done;
    logic              err;
    logic [AWIDTH-1:0] host_addr;
    logic [DWIDTH-1:0] host_d;
    logic              host_we;
    logic              host_ready;
    logic [AWIDTH-1:0] cr_addr;
    logic [DWIDTH-1:0] cr_d;
    logic              cr_we;

    modport master (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_width, cmd_fill, cmd_cout,
        output host_addr, host_d, host_we,
        input  cmd_ready, done, err, host_ready, cr_addr, cr_d, cr_we
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_width, cmd_fill, cmd_cout,
        input  host_addr, host_d, host_we,
        output cmd_ready, done, err, host_ready, cr_addr, cr_d, cr_we
    );
endinterface

// File: rtl/comefa_cmd_enc.sv
// Packs named compute-word fields into the 40-bit comefa command (dummy bits 37:35 = 0).
// Latency: combinational, zero cycles; the caller registers the result.
// No flow control.
module comefa_cmd_enc
    import comefa_pkg::*;
(
    input  cmd_fields_t      f,
    output logic [CMD_W-1:0] word
);

    // Place each field at its fixed bit position
    always_comb begin
        word                    = '0;
        word[POS_PRED +: 2]     = f.pred;
        word[POS_BSEL]          = f.b_sel;
        word[POS_BDATA]         = f.b_data;
        word[POS_WEN]           = f.write_en;
        word[POS_WSEL +: 2]     = f.write_sel;
        word[POS_PORT]          = f.port;
        word[POS_CRST]          = f.c_rst;
        word[POS_CEN]           = f.c_en;
        word[POS_MRST]          = f.m_rst;
        word[POS_MEN]           = f.m_en;
        word[POS_TT +: 4]       = f.tt;
        word[POS_DST +: ROW_W]  = f.dst;
        word[POS_SRC2 +: ROW_W] = f.src2;
        word[POS_SRC1 +: ROW_W] = f.src1;
    end

endmodule

// File: rtl/comefa_seq.sv
// Macro-op sequencer: expands ADD/COPY/FILL into bit-serial compute words for one comefa RAM.
// Latency: PRE word 1 cycle after accept, W bit words, optional carry word, done the cycle after.
// Backpressure: cmd_ready only in IDLE; host writes are held off (host_ready=0) while busy.
module comefa_seq
    import comefa_pkg::*;
#(
    parameter int                AWIDTH   = 9,
    parameter int                DWIDTH   = 40,
    parameter logic [AWIDTH-1:0] CMD_ADDR = 9'h1FF,
    parameter int                NUM_ROWS = 128
) (
    input  logic        clk,
    input  logic        reset,
    comefa_seq_if.slave bus
);

    localparam logic [7:0] MAX_ROW = 8'(NUM_ROWS - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ROW_W-1:0]  src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic [4:0]        wm_q, wm_d;
    logic              fill_q, fill_d, cout_q, cout_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              cr_we_q, cr_we_d;
    logic [AWIDTH-1:0] cr_addr_q, cr_addr_d;
    logic [DWIDTH-1:0] cr_d_q, cr_d_d;
    logic              done_q, done_d, err_q, err_d;

    word_kind_e        kind;
    cmd_fields_t       fields;
    logic [CMD_W-1:0]  enc_word;
    logic              accept, legal, host_fire;
    logic              s1_bad, s2_bad, d_bad;
    logic [4:0]        bit_idx;

    assign accept    = bus.cmd_valid && (state_q == ST_IDLE);
    assign host_fire = bus.host_we && bus.host_ready;
    assign bit_idx   = cnt_q[4:0];

    assign s1_bad = top_row(bus.cmd_src1, bus.cmd_width) > MAX_ROW;
    assign s2_bad = top_row(bus.cmd_src2, bus.cmd_width) > MAX_ROW;
    assign d_bad  = top_row(bus.cmd_dst,  bus.cmd_width) > MAX_ROW;

    // Legality of the offered command: only operands the op actually reads or writes are range-checked
    always_comb begin
        legal = 1'b0;
        case (op_e'(bus.cmd_op))
            OP_ADD:  legal = !(s1_bad || s2_bad || d_bad);
            OP_COPY: legal = !(s1_bad || d_bad);
            OP_FILL: legal = !d_bad;
            default: legal = 1'b0;
        endcase
        if (bus.cmd_cout && (bus.cmd_dst == '0)) begin
            legal = 1'b0;
        end
    end

    // Sequencing: capture at accept, PRE clears carry, one word per bit LSB first, optional carry word
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dst_d   = dst_q;
        wm_d    = wm_q;
        fill_d  = fill_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        kind    = K_NONE;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = op_e'(bus.cmd_op);
                    src1_d = bus.cmd_src1;
                    src2_d = bus.cmd_src2;
                    dst_d  = bus.cmd_dst;
                    wm_d   = bus.cmd_width;
                    fill_d = bus.cmd_fill;
                    cout_d = bus.cmd_cout;
                    cnt_d  = '0;
                    if (legal) begin
                        state_d = ST_PRE;
                        kind    = K_PRE;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_PRE, ST_BIT: begin
                // cnt_q is the index of the next bit to issue
                if (cnt_q == ({1'b0, wm_q} + 6'd1)) begin
                    if ((op_q == OP_ADD) && cout_q) begin
                        state_d = ST_COUT;
                        kind    = K_COUT;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_BIT;
                    kind    = K_BIT;
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            ST_COUT: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Field selection for the word launched next cycle
    always_comb begin
        fields      = '0;
        fields.pred = PRED_ALL;
        case (kind)
            K_PRE: fields.c_rst = 1'b1;
            K_BIT: begin
                fields.write_en  = 1'b1;
                fields.write_sel = WSEL_SUM;
                fields.dst       = bit_row(dst_q, wm_q, bit_idx);
                case (op_q)
                    OP_ADD: begin
                        fields.tt   = TT_XOR;
                        fields.c_en = 1'b1;
                        fields.src1 = bit_row(src1_q, wm_q, bit_idx);
                        fields.src2 = bit_row(src2_q, wm_q, bit_idx);
                    end
                    OP_COPY: begin
                        fields.tt   = TT_PASS1;
                        fields.src1 = bit_row(src1_q, wm_q, bit_idx);
                    end
                    OP_FILL: begin
                        fields.tt     = TT_PASS2;
                        fields.b_sel  = 1'b1;
                        fields.b_data = fill_q;
                    end
                    default: fields.write_en = 1'b0;
                endcase
            end
            K_COUT: begin
                fields.write_en  = 1'b1;
                fields.write_sel = WSEL_SUM;
                fields.port      = 1'b1;
                fields.dst       = dst_q - 7'd1;
            end
            default: fields.pred = PRED_ALL;
        endcase
    end

    comefa_cmd_enc u_enc (
        .f    (fields),
        .word (enc_word)
    );

    // Write-port mux: compute words win; host writes pass only when idle and no command is offered
    always_comb begin
        cr_we_d   = 1'b0;
        cr_addr_d = cr_addr_q;
        cr_d_d    = cr_d_q;
        if (kind != K_NONE) begin
            cr_we_d   = 1'b1;
            cr_addr_d = CMD_ADDR;
            cr_d_d    = enc_word;
        end else if (host_fire) begin
            cr_we_d   = 1'b1;
            cr_addr_d = bus.host_addr;
            cr_d_d    = bus.host_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            src1_q    <= '0;
            src2_q    <= '0;
            dst_q     <= '0;
            wm_q      <= '0;
            fill_q    <= 1'b0;
            cout_q    <= 1'b0;
            cnt_q     <= '0;
            cr_we_q   <= 1'b0;
            cr_addr_q <= '0;
            cr_d_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            dst_q     <= dst_d;
            wm_q      <= wm_d;
            fill_q    <= fill_d;
            cout_q    <= cout_d;
            cnt_q     <= cnt_d;
            cr_we_q   <= cr_we_d;
            cr_addr_q <= cr_addr_d;
            cr_d_q    <= cr_d_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.host_ready = (state_q == ST_IDLE) && !bus.cmd_valid;
    assign bus.cr_we      = cr_we_q;
    assign bus.cr_addr    = cr_addr_q;
    assign bus.cr_d       = cr_d_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_comefa_seq.sv
// Directed bench for comefa_seq with a bit-level comefa RAM model fed from the write port.
// Outputs are sampled on the falling edge; inputs change just after it.
// Expected results are hand-computed operand values and cycle offsets.
module tb_comefa_seq;
    import comefa_pkg::*;

    localparam logic [8:0] CMD_ADDR = 9'h1FF;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    comefa_seq_if #(.AWIDTH(9), .DWIDTH(40)) bus ();

    comefa_seq #(
        .AWIDTH   (9),
        .DWIDTH   (40),
        .CMD_ADDR (9'h1FF),
        .NUM_ROWS (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          vec_cnt = 0;
    int          mis_cnt = 0;
    int          cyc = 0;
    int          word_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          pre_cyc = 0;
    int          host_cnt = 0;
    int          host_cyc = 0;
    logic        err_last = 1'b0;
    logic [8:0]  host_a = '0;
    logic [39:0] host_dv = '0;
    logic [39:0] pre_word = '0;
    logic [39:0] mem [0:127];
    logic [39:0] carry = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial comefa column model: a = src1 row, b = src2 row or b_data
    task automatic apply_word(input logic [39:0] w);
        logic        a, b, cin, tv, res;
        logic [39:0] nd;
        int          idx;
        nd = mem[w[20:14]];
        for (int c = 0; c < 40; c++) begin
            a   = mem[w[6:0]][c];
            b   = w[34] ? w[33] : mem[w[13:7]][c];
            cin = w[28] ? 1'b0 : carry[c];
            idx = 21 + 2 * int'(b) + int'(a);
            tv  = w[idx];
            res = w[29] ? cin : (tv ^ cin);
            carry[c] = w[27] ? ((a & b) | (a & cin) | (b & cin)) : cin;
            nd[c] = res;
        end
        if (w[32]) mem[w[20:14]] = nd;
    endtask

    task automatic load_col(input int base, input int w, input logic [31:0] val);
        for (int i = 0; i < w; i++) mem[base + w - 1 - i] = {40{val[i]}};
    endtask

    function automatic logic [31:0] col_val(input int base, input int w, input int col);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < w; i++) v[i] = mem[base + w - 1 - i][col];
        return v;
    endfunction

    // One cycle: sample at the falling edge and feed the RAM model / event recorders
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.cr_we) begin
            if (bus.cr_addr == CMD_ADDR && bus.cr_d[39:38] == 2'b11) begin
                word_cnt++;
                if (bus.cr_d[28]) begin
                    pre_cyc  = cyc;
                    pre_word = bus.cr_d;
                end
                apply_word(bus.cr_d);
            end else begin
                host_cnt++;
                host_cyc = cyc;
                host_a   = bus.cr_addr;
                host_dv  = bus.cr_d;
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            err_last = bus.err;
        end
    endtask

    // Offer one command, scramble the fields after acceptance, wait (bounded) for done
    task automatic run_cmd(input logic [1:0] op, input int s1, input int s2, input int d,
                           input int wm, input logic fill, input logic cout,
                           output int lat, output int words, output logic e);
        int t0, w0, d0;
        bus.cmd_op    = op;
        bus.cmd_src1  = 7'(s1);
        bus.cmd_src2  = 7'(s2);
        bus.cmd_dst   = 7'(d);
        bus.cmd_width = 5'(wm);
        bus.cmd_fill  = fill;
        bus.cmd_cout  = cout;
        bus.cmd_valid = 1'b1;
        t0 = cyc;
        w0 = word_cnt;
        d0 = done_cnt;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_src1  = ~7'(s1);
        bus.cmd_src2  = ~7'(s2);
        bus.cmd_dst   = ~7'(d);
        bus.cmd_width = ~5'(wm);
        bus.cmd_fill  = ~fill;
        bus.cmd_cout  = ~cout;
        for (int k = 0; k < 60 && done_cnt == d0; k++) tick();
        lat   = (done_cnt == d0) ? -1 : done_cyc - t0;
        words = word_cnt - w0;
        e     = err_last;
    endtask

    int   lat, wds, t0, w0, d0, h0;
    logic e;

    initial begin
        for (int r = 0; r < 128; r++) mem[r] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_src1  = '0;
        bus.cmd_src2  = '0;
        bus.cmd_dst   = '0;
        bus.cmd_width = '0;
        bus.cmd_fill  = 1'b0;
        bus.cmd_cout  = 1'b0;
        bus.host_addr = '0;
        bus.host_d    = '0;
        bus.host_we   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cr_we", bus.cr_we, 0);
        check("rst_done", bus.done, 0);
        reset = 1'b0;
        tick();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_host_ready", bus.host_ready, 1);
        check("rst_err", bus.err, 0);
        check("rst_cr_addr", bus.cr_addr, 0);
        check("rst_cr_d", bus.cr_d, 0);

        // ADD 0x5A + 0x3C -> 0x96, no carry write
        load_col(3, 8, 32'h5A);
        load_col(11, 8, 32'h3C);
        load_col(19, 8, 32'h00);
        run_cmd(2'b00, 3, 11, 19, 7, 1'b0, 1'b0, lat, wds, e);
        check("add_lat", lat, 10);
        check("add_words", wds, 9);
        check("add_err", e, 0);
        check("add_pre_word", pre_word, 40'hC010000000);
        check("add_sum_c0", col_val(19, 8, 0), 32'h96);
        check("add_sum_c39", col_val(19, 8, 39), 32'h96);

        // ADD 0xF0 + 0x20 with carry write to dst-1
        load_col(60, 8, 32'hF0);
        load_col(70, 8, 32'h20);
        mem[19] = '0;
        run_cmd(2'b00, 60, 70, 20, 7, 1'b0, 1'b1, lat, wds, e);
        check("addc_lat", lat, 11);
        check("addc_words", wds, 10);
        check("addc_sum", col_val(20, 8, 5), 32'h10);
        check("addc_carry_row", mem[19], 40'hFF_FFFF_FFFF);

        // FILL ones into rows 40..43, then COPY them to 50..53
        load_col(40, 4, 32'h0);
        load_col(50, 4, 32'h0);
        run_cmd(2'b10, 0, 0, 40, 3, 1'b1, 1'b0, lat, wds, e);
        check("fill_lat", lat, 6);
        check("fill_val", col_val(40, 4, 17), 32'hF);
        run_cmd(2'b01, 40, 0, 50, 3, 1'b0, 1'b0, lat, wds, e);
        check("copy_lat", lat, 6);
        check("copy_val", col_val(50, 4, 33), 32'hF);

        // COPY of an asymmetric pattern (bit order)
        load_col(80, 8, 32'hA7);
        run_cmd(2'b01, 80, 5, 90, 7, 1'b0, 1'b0, lat, wds, e);
        check("copy_order", col_val(90, 8, 2), 32'hA7);

        // Range boundary: top row 127 accepted, 128 rejected
        run_cmd(2'b10, 0, 0, 125, 2, 1'b1, 1'b0, lat, wds, e);
        check("edge127_lat", lat, 5);
        check("edge127_err", e, 0);
        run_cmd(2'b10, 0, 0, 126, 2, 1'b1, 1'b0, lat, wds, e);
        check("edge128_lat", lat, 1);
        check("edge128_err", e, 1);
        check("edge128_words", wds, 0);

        // Rejections
        run_cmd(2'b00, 120, 11, 19, 15, 1'b0, 1'b0, lat, wds, e);
        check("rej_rng_lat", lat, 1);
        check("rej_rng_err", e, 1);
        check("rej_rng_words", wds, 0);
        run_cmd(2'b11, 3, 11, 19, 7, 1'b0, 1'b0, lat, wds, e);
        check("rej_op_lat", lat, 1);
        check("rej_op_err", e, 1);
        check("rej_op_words", wds, 0);
        run_cmd(2'b00, 3, 11, 0, 7, 1'b0, 1'b1, lat, wds, e);
        check("rej_cout0_err", e, 1);
        check("rej_cout0_words", wds, 0);

        // Raw host write to CMD_ADDR passes through unchanged, one cycle later
        bus.host_addr = CMD_ADDR;
        bus.host_d    = 40'h00_1234_5678;
        bus.host_we   = 1'b1;
        #1;
        check("raw_host_ready", bus.host_ready, 1);
        t0 = cyc;
        h0 = host_cnt;
        tick();
        bus.host_we = 1'b0;
        check("raw_host_cnt", host_cnt - h0, 1);
        check("raw_host_lat", host_cyc - t0, 1);
        check("raw_host_addr", host_a, 9'h1FF);
        check("raw_host_data", host_dv, 40'h00_1234_5678);

        // Host write offered together with an ADD: command wins, host waits until done
        bus.cmd_op    = 2'b00;
        bus.cmd_src1  = 7'd3;
        bus.cmd_src2  = 7'd11;
        bus.cmd_dst   = 7'd100;
        bus.cmd_width = 5'd7;
        bus.cmd_fill  = 1'b0;
        bus.cmd_cout  = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.host_addr = 9'h005;
        bus.host_d    = 40'hAB_CDEF_0123;
        bus.host_we   = 1'b1;
        #1;
        check("arb_host_ready", bus.host_ready, 0);
        t0 = cyc;
        h0 = host_cnt;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 40 && !bus.host_ready; k++) tick();
        check("arb_ready_cyc", cyc - t0, 10);
        check("arb_done_with_ready", bus.done, 1);
        tick();
        bus.host_we = 1'b0;
        check("arb_host_cnt", host_cnt - h0, 1);
        check("arb_host_lat", host_cyc - t0, 11);
        check("arb_host_addr", host_a, 9'h005);
        check("arb_host_data", host_dv, 40'hAB_CDEF_0123);
        check("arb_sum", col_val(100, 8, 0), 32'h96);

        // Reset during the 4th BIT cycle
        bus.cmd_op    = 2'b00;
        bus.cmd_src1  = 7'd3;
        bus.cmd_src2  = 7'd11;
        bus.cmd_dst   = 7'd110;
        bus.cmd_width = 5'd7;
        bus.cmd_valid = 1'b1;
        t0 = cyc;
        w0 = word_cnt;
        d0 = done_cnt;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_cr_we", bus.cr_we, 0);
        check("mid_rst_ready", bus.cmd_ready, 1);
        reset = 1'b0;
        repeat (10) tick();
        check("mid_rst_words", word_cnt - w0, 5);
        check("mid_rst_no_done", done_cnt - d0, 0);

        // Back-to-back ADDs with cmd_valid held: 5+3 then 9+4
        load_col(30, 4, 32'h5);
        load_col(34, 4, 32'h3);
        load_col(116, 4, 32'h9);
        load_col(120, 4, 32'h4);
        bus.cmd_op    = 2'b00;
        bus.cmd_src1  = 7'd30;
        bus.cmd_src2  = 7'd34;
        bus.cmd_dst   = 7'd112;
        bus.cmd_width = 5'd3;
        bus.cmd_cout  = 1'b0;
        bus.cmd_valid = 1'b1;
        t0 = cyc;
        d0 = done_cnt;
        tick();
        bus.cmd_src1 = 7'd116;
        bus.cmd_src2 = 7'd120;
        bus.cmd_dst  = 7'd124;
        for (int k = 0; k < 40 && done_cnt == d0; k++) tick();
        check("b2b_done1", done_cyc - t0, 6);
        check("b2b_ready_at_done", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("b2b_pre2", pre_cyc - t0, 7);
        for (int k = 0; k < 40 && done_cnt < d0 + 2; k++) tick();
        check("b2b_done2", done_cyc - t0, 12);
        check("b2b_sum1", col_val(112, 4, 0), 32'h8);
        check("b2b_sum2", col_val(124, 4, 0), 32'hD);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
